// File: rtl/ram32k_pkg.sv
// Shared definitions for the RAM32K arbiter: RAM geometry, the arbiter's
// state encoding and the identifiers used to tag which port owns a read.
package ram32k_pkg;

  localparam int RAM_AW = 15;
  localparam int RAM_DW = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic port_t;

  localparam port_t PORT_A = 1'b0;
  localparam port_t PORT_B = 1'b1;

endpackage

// File: rtl/ram32k_arbiter.sv
// ram32k_arbiter: shares one byte-wide 32 KB SPRAM between the core (port A)
// and the boot loader / debug DMA (port B). Grants are same-cycle, read data
// returns one cycle later to whichever port issued the read. Port B may lock
// the RAM for bursts; a starvation counter forces a release to A after
// MAX_LOCK locked cycles in which A was waiting.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on contention
// instead of fixed priority to port A).
module ram32k_arbiter
  import ram32k_pkg::*;
#(
  parameter int MAX_LOCK = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [RAM_AW-1:0] a_addr,
  input  logic [RAM_DW-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [RAM_AW-1:0] b_addr,
  input  logic [RAM_DW-1:0] b_wdata,
  input  logic              b_lock,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [RAM_DW-1:0] a_rdata,
  output logic [RAM_DW-1:0] b_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  output logic              ram_we,
  input  logic [RAM_DW-1:0] ram_dout
);

  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     lock_cnt;
  logic [CW-1:0]     next_cnt;
  logic              open_a;
  logic              open_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rd_grant;
  port_t             rd_winner;
  logic              rd_pend;
  port_t             rd_owner;
  logic [RAM_AW-1:0] addr_q;

`ifdef ARB_ROUND_ROBIN_EN
  port_t             last_winner;

  // Remember which port won most recently so contention alternates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner <= PORT_B;
    end else if (gnt_a) begin
      last_winner <= PORT_A;
    end else if (gnt_b) begin
      last_winner <= PORT_B;
    end else begin
      last_winner <= last_winner;
    end
  end
`endif

  // Unlocked arbitration: single requester wins, contention resolved by policy
  always_comb begin
    open_a = 1'b0;
    open_b = 1'b0;
    if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_winner == PORT_A) begin
        open_b = 1'b1;
      end else begin
        open_a = 1'b1;
      end
`else
      open_a = 1'b1;
`endif
    end else begin
      open_a = a_req;
      open_b = b_req;
    end
  end

  // Grant selection, lock state transitions and starvation counter
  always_comb begin
    next_state = state;
    next_cnt   = lock_cnt;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    if (rst) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          gnt_a    = open_a;
          gnt_b    = open_b;
          next_cnt = '0;
          if (open_b && b_lock) begin
            next_state = LOCKED;
          end else begin
            next_state = IDLE;
          end
        end
        LOCKED: begin
          if (!b_lock) begin
            // B has let go: this cycle is arbitrated as if unlocked
            gnt_a      = open_a;
            gnt_b      = open_b;
            next_state = IDLE;
            next_cnt   = '0;
          end else if (a_req && (lock_cnt == LOCK_MAX)) begin
            // A has waited long enough: break the lock in its favour
            gnt_a      = 1'b1;
            next_state = IDLE;
            next_cnt   = '0;
          end else begin
            gnt_b      = b_req;
            next_state = LOCKED;
            if (!a_req) begin
              next_cnt = '0;
            end else if (lock_cnt != LOCK_MAX) begin
              next_cnt = lock_cnt + CW'(1);
            end else begin
              next_cnt = lock_cnt;
            end
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // State register and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= next_state;
      lock_cnt <= next_cnt;
    end
  end

  // RAM-side mux: follow the winner, park on the last address when idle
  always_comb begin
    ram_addr  = addr_q;
    ram_din   = a_wdata;
    ram_we    = 1'b0;
    rd_grant  = 1'b0;
    rd_winner = PORT_A;
    if (gnt_b) begin
      ram_addr  = b_addr;
      ram_din   = b_wdata;
      ram_we    = b_we;
      rd_grant  = ~b_we;
      rd_winner = PORT_B;
    end else if (gnt_a) begin
      ram_addr  = a_addr;
      ram_din   = a_wdata;
      ram_we    = a_we;
      rd_grant  = ~a_we;
      rd_winner = PORT_A;
    end else begin
      ram_addr  = addr_q;
    end
  end

  // Held address and read-return tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= PORT_A;
    end else begin
      if (gnt_a || gnt_b) begin
        addr_q <= ram_addr;
      end else begin
        addr_q <= addr_q;
      end
      rd_pend <= rd_grant;
      if (rd_grant) begin
        rd_owner <= rd_winner;
      end else begin
        rd_owner <= rd_owner;
      end
    end
  end

  assign a_gnt    = gnt_a;
  assign b_gnt    = gnt_b;
  assign a_rvalid = rd_pend && (rd_owner == PORT_A);
  assign b_rvalid = rd_pend && (rd_owner == PORT_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule
